// File: rtl/hv_bundle.sv
// Majority bundler: accumulates encoded hypervectors on two lanes into per-bit
// counters, then thresholds each lane against n/2 with a tie-break vector.
module hv_lane #(
  parameter int CNT_W = 8,
  parameter int VEC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             ld,
  input  logic [VEC_W-1:0] d,
  input  logic [VEC_W-1:0] tie,
  input  logic [CNT_W-1:0] n,
  output logic [VEC_W-1:0] q
);
  logic [VEC_W-1:0][CNT_W-1:0] cnt;
  logic [VEC_W-1:0]            maj;

  // 2*cnt vs n compared at CNT_W+1 bits so a full counter never wraps
  always_comb begin
    maj = '0;
    for (int k = 0; k < VEC_W; k++) begin
      if ({cnt[k], 1'b0} > {1'b0, n})       maj[k] = 1'b1;
      else if ({cnt[k], 1'b0} == {1'b0, n}) maj[k] = tie[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      q   <= '0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (inc)
        for (int k = 0; k < VEC_W; k++) cnt[k] <= cnt[k] + CNT_W'(d[k]);
      if (ld) q <= maj;
    end
  end
endmodule

module hv_bundle #(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_d_1,
  input  logic [31:0] in_d_2,
  input  logic        finish,
  input  logic [31:0] tie_d,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_d_1,
  output logic [31:0] out_d_2,
  output logic        busy,
  output logic        ovf
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 32;
  localparam logic [CNT_W-1:0] N_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, THRESH, DONE} state_t;

  state_t                            state;
  logic [CNT_W-1:0]                  n;
  logic [NUM_LANES-1:0][VEC_W-1:0]   lane_d, lane_q;
  logic                              accept, ld;

  // start outranks a same-cycle in_valid, so a restart never counts that vector
  assign accept = (state == ACCUM) && in_valid && !start && (n != N_MAX);
  assign ld     = (state == THRESH) && !start;
  assign lane_d = {in_d_2, in_d_1};
  assign out_d_1 = lane_q[0];
  assign out_d_2 = lane_q[1];
  assign busy    = (state != IDLE);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    hv_lane #(.CNT_W(CNT_W), .VEC_W(VEC_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .inc (accept),
      .ld  (ld),
      .d   (lane_d[l]),
      .tie (tie_d),
      .n   (n),
      .q   (lane_q[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (start) begin
      state     <= ACCUM;
      n         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (n != N_MAX) n   <= n + 1'b1;
            else            ovf <= 1'b1;
          end
          if (finish) state <= THRESH;
        end
        THRESH: begin
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hv_bundle.sv
// Directed bench for hv_bundle: two instances (CNT_W=8 and CNT_W=2) share stimulus;
// a bit-count model pushes expected majorities to a queue checked on out_valid.
module tb_hv_bundle;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, finish, out_ready;
  logic [31:0] in_d_1, in_d_2, tie_d;
  logic        out_valid_a, busy_a, ovf_a, out_valid_b, busy_b, ovf_b;
  logic [31:0] out_d_1_a, out_d_2_a, out_d_1_b, out_d_2_b;

  typedef struct {
    logic [31:0] a1, a2, b1, b2;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  int   ca[2][32], cb[2][32];
  int   na, nb;

  always #5 clk = ~clk;

  hv_bundle #(.CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_d_1(in_d_1),
    .in_d_2(in_d_2), .finish(finish), .tie_d(tie_d), .out_ready(out_ready),
    .out_valid(out_valid_a), .out_d_1(out_d_1_a), .out_d_2(out_d_2_a),
    .busy(busy_a), .ovf(ovf_a)
  );

  hv_bundle #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_d_1(in_d_1),
    .in_d_2(in_d_2), .finish(finish), .tie_d(tie_d), .out_ready(out_ready),
    .out_valid(out_valid_b), .out_d_1(out_d_1_b), .out_d_2(out_d_2_b),
    .busy(busy_b), .ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear;
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 32; k++) begin
        ca[l][k] = 0;
        cb[l][k] = 0;
      end
    na = 0;
    nb = 0;
  endtask

  task automatic m_acc(input logic [31:0] d1, input logic [31:0] d2);
    if (na < 255) begin
      for (int k = 0; k < 32; k++) begin
        ca[0][k] += int'(d1[k]);
        ca[1][k] += int'(d2[k]);
      end
      na++;
    end
    if (nb < 3) begin
      for (int k = 0; k < 32; k++) begin
        cb[0][k] += int'(d1[k]);
        cb[1][k] += int'(d2[k]);
      end
      nb++;
    end
  endtask

  function automatic logic maj_bit(input int c, input int n, input logic t);
    if (2 * c > n) return 1'b1;
    if (2 * c == n) return t;
    return 1'b0;
  endfunction

  task automatic m_push(input logic [31:0] tie);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.a1[k] = maj_bit(ca[0][k], na, tie[k]);
      e.a2[k] = maj_bit(ca[1][k], na, tie[k]);
      e.b1[k] = maj_bit(cb[0][k], nb, tie[k]);
      e.b2[k] = maj_bit(cb[1][k], nb, tie[k]);
    end
    q.push_back(e);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_clear();
  endtask

  task automatic do_vec(input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1'b1;
    in_d_1   = d1;
    in_d_2   = d2;
    tick();
    in_valid = 1'b0;
    m_acc(d1, d2);
  endtask

  // finish at edge t: THRESH in t+1, out_valid from t+2
  task automatic do_finish(input logic [31:0] tie);
    tie_d  = tie;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    m_push(tie);
    chk("lat_t1_valid", {31'b0, out_valid_a}, 32'd0);
    chk("lat_t1_busy", {31'b0, busy_a}, 32'd1);
    tick();
    chk("lat_t2_valid", {31'b0, out_valid_a}, 32'd1);
  endtask

  task automatic take_out(input int hold);
    exp_t e;
    int   cyc = 0;
    while (!out_valid_a && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("out_valid_wait", {31'b0, out_valid_a}, 32'd1);
    if (q.size() == 0) begin
      chk("sb_nonempty", 32'(q.size()), 32'd1);
      return;
    end
    e = q.pop_front();
    chk("a_d1", out_d_1_a, e.a1);
    chk("a_d2", out_d_2_a, e.a2);
    chk("b_d1", out_d_1_b, e.b1);
    chk("b_d2", out_d_2_b, e.b2);
    chk("b_valid", {31'b0, out_valid_b}, 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", {31'b0, out_valid_a}, 32'd1);
      chk("hold_d1", out_d_1_a, e.a1);
      chk("hold_d2", out_d_2_a, e.a2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("acc_valid", {31'b0, out_valid_a}, 32'd0);
    chk("acc_busy", {31'b0, busy_a}, 32'd0);
    chk("acc_keep_d1", out_d_1_a, e.a1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; finish = 1'b0; out_ready = 1'b0;
    in_d_1 = '0; in_d_2 = '0; tie_d = '0;
    m_clear();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", {31'b0, out_valid_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_ovf", {31'b0, ovf_a}, 32'd0);
    chk("rst_d1", out_d_1_a, 32'd0);
    chk("rst_d2", out_d_2_a, 32'd0);

    // majority of 3
    do_start();
    chk("start_busy", {31'b0, busy_a}, 32'd1);
    do_vec(32'hFFFF0000, 32'hFFFFFFFF);
    do_vec(32'hFF00FF00, 32'hFFFFFFFF);
    do_vec(32'hF0F0F0F0, 32'hFFFFFFFF);
    do_finish(32'h0);
    chk("maj3_d1", out_d_1_a, 32'hFFF0F000);
    chk("maj3_d2", out_d_2_a, 32'hFFFFFFFF);
    take_out(0);

    // tie-break
    do_start();
    do_vec(32'h0000FFFF, 32'h0);
    do_vec(32'h00FF00FF, 32'h0);
    do_finish(32'hAAAAAAAA);
    chk("tie_d1", out_d_1_a, 32'h00AAAAFF);
    chk("tie_d2", out_d_2_a, 32'h00000000);
    take_out(0);

    // random set with backpressure
    do_start();
    for (int i = 0; i < 6; i++) do_vec($urandom, $urandom);
    do_finish($urandom);
    take_out(5);

    // restart mid-set: same-cycle vector is dropped
    do_start();
    do_vec(32'hFFFFFFFF, 32'hFFFFFFFF);
    do_vec(32'hFFFFFFFF, 32'hFFFFFFFF);
    start = 1'b1; in_valid = 1'b1; in_d_1 = '1; in_d_2 = '1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    m_clear();
    do_vec(32'h0, 32'h0);
    do_finish(32'h12345678);
    chk("rs_d1", out_d_1_a, 32'h0);
    chk("rs_d2", out_d_2_a, 32'h0);
    take_out(0);

    // saturation on the CNT_W=2 instance
    do_start();
    for (int i = 0; i < 4; i++) do_vec(32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("sat_ovf_b", {31'b0, ovf_b}, 32'd1);
    chk("sat_ovf_a", {31'b0, ovf_a}, 32'd0);
    do_finish(32'h0);
    chk("sat_b_d1", out_d_1_b, 32'hFFFFFFFF);
    chk("sat_b_d2", out_d_2_b, 32'hFFFFFFFF);
    take_out(0);
    do_start();
    chk("sat_clr_ovf", {31'b0, ovf_b}, 32'd0);

    // reset in ACCUM, with out_d still holding all-ones
    do_vec(32'hFFFFFFFF, 32'h0F0F0F0F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_clear();
    chk("mrst_valid", {31'b0, out_valid_a}, 32'd0);
    chk("mrst_busy", {31'b0, busy_a}, 32'd0);
    chk("mrst_d1", out_d_1_a, 32'd0);
    chk("mrst_d2", out_d_2_a, 32'd0);
    chk("mrst_d1_b", out_d_1_b, 32'd0);

    // empty set returns tie_d
    do_start();
    do_finish(32'h5A5A5A5A);
    chk("empty_d1", out_d_1_a, 32'h5A5A5A5A);
    chk("empty_d2", out_d_2_a, 32'h5A5A5A5A);
    take_out(0);

    // start wins on the accepting edge
    do_start();
    do_vec(32'h0000FFFF, 32'hFFFF0000);
    do_finish(32'h0);
    void'(q.pop_front());
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    m_clear();
    chk("b2b_valid", {31'b0, out_valid_a}, 32'd0);
    chk("b2b_busy", {31'b0, busy_a}, 32'd1);
    do_vec(32'h00000001, 32'h80000000);
    do_finish(32'h0);
    take_out(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hv_bundle.md
# hv_bundle

Bundling stage directly downstream of the encoder core. It accumulates a set of encoded 32-bit hypervectors on two independent lanes. It then reduces each lane to one 32-bit majority hypervector, using per-bit counters and a bitwise majority threshold. Ties are resolved from a supplied tie-break vector, and the result is presented to the next stage over a valid/ready handshake.

## Interface
- CNT_W, 8: width of each per-bit counter and of the vector counter n; max set size 2^CNT_W-1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; clears counters and n; enters ACCUM.
- in_valid  in  1  one encoded vector per lane present this cycle; driven from the encoder's update strobe.
- in_d_1  in  32  lane-1 encoded vector (encoder result_1).
- in_d_2  in  32  lane-2 encoded vector (encoder result_2).
- finish  in  1  pulse; end of set.
- tie_d  in  32  tie-break vector, shared by both lanes; sampled in THRESH.
- out_ready  in  1  downstream accepts the output.
- out_valid  out  1  majority vectors valid.
- out_d_1  out  32  lane-1 majority vector.
- out_d_2  out  32  lane-2 majority vector.
- busy  out  1  state is not IDLE.
- ovf  out  1  sticky: an in_valid was dropped because n was saturated; cleared by start or rst.

## Operation
- Storage: 64 counters of CNT_W bits (32 per lane), plus n (CNT_W bits) counting accepted vectors.
- FSM states: IDLE, ACCUM, THRESH, DONE.
- IDLE, start=1 -> ACCUM. Counters, n and ovf are cleared.
- ACCUM:
  - in_valid=1 and n < 2^CNT_W-1: each lane counter k increments by in_d_x[k], and n increments.
  - in_valid=1 and n saturated: the vector is dropped and ovf<=1.
  - finish=1 -> THRESH. A same-cycle in_valid is counted first.
- THRESH, per lane bit k:
  - 2*cnt > n: bit is 1.
  - 2*cnt == n: bit is tie_d[k].
  - otherwise: bit is 0.
  - The comparison is CNT_W+1 bits wide with no truncation.
  - Registers out_d_1 and out_d_2, sets out_valid, then -> DONE.
- DONE: out_valid and out_d are held stable until out_ready=1. On that edge out_valid<=0 -> IDLE; out_d keeps its last value.
- in_valid outside ACCUM: ignored.
- finish outside ACCUM: ignored.
- start has priority over everything except rst, in any state:
  - In ACCUM it restarts the set; a same-cycle in_valid is dropped, not counted.
  - In DONE it discards the pending output (out_valid<=0).
- Empty set (finish with n=0): every bit ties, so the output equals tie_d on both lanes.

## Timing
- Reset: after a rst edge, state=IDLE; all counters, n, ovf, out_valid, busy and out_d_1/out_d_2 are 0. rst applies mid-operation with the same effect; any pending output is lost.
- in_valid at edge t: its contribution is visible in the counters after edge t.
- finish sampled at edge t: THRESH in cycle t+1; out_valid=1 and out_d valid from t+2.
- Minimum finish-to-out_valid latency: 2 cycles.
- Handshake: transfer occurs when out_valid and out_ready are both 1 at an edge. out_valid drops the next cycle. out_ready while out_valid=0 has no effect.
- busy=1 from the cycle after start through the cycle of the accepting edge.
- Back-to-back sets: start may be asserted in the cycle after acceptance. It is also accepted in the acceptance cycle itself, and start wins there.

## Test plan
- Majority of 3: start; in_d_1 = 0xFFFF0000, 0xFF00FF00, 0xF0F0F0F0; in_d_2 = 0xFFFFFFFF ×3; finish; out_ready=1 -> out_d_1=0xFFF0F000, out_d_2=0xFFFFFFFF, out_valid exactly 2 cycles after finish.
- Tie-break: in_d_1 = 0x0000FFFF, 0x00FF00FF; in_d_2 = 0x0, 0x0; tie_d=0xAAAAAAAA -> out_d_1=0x00AAAAFF, out_d_2=0x00000000.
- Saturation (CNT_W=2): 4× in_valid with 0xFFFFFFFF on both lanes; finish -> ovf=1, n=3, out_d_1=out_d_2=0xFFFFFFFF. A following start clears ovf.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> out_valid and out_d stable throughout. out_ready=1 -> out_valid=0 and busy=0 next cycle.
- Restart mid-set: 2 vectors of 0xFFFFFFFF, then start together with in_valid, then 1 vector of 0x00000000, finish, tie_d=0x12345678 -> both outputs 0x00000000; the earlier vectors and the same-cycle vector are discarded.
- Reset mid-operation and empty set: rst during ACCUM -> all outputs 0 the next cycle. Then start, finish with no vectors, tie_d=0x5A5A5A5A -> out_d_1=out_d_2=0x5A5A5A5A.
